rx_huge_page_cfg_decoder: RTL and testbench

//  Snoops the 64-bit TRN RX stream and decodes host MWr32/MWr64 TLPs hitting BAR_NUM into a per-page register file.

---
 rtl/rx_huge_page_cfg_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_rx_huge_page_cfg_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_huge_page_cfg_decoder.sv
// rx_huge_page_cfg_decoder
// Snoops the 64-bit TRN RX stream for host MWr32/MWr64 TLPs that hit BAR_NUM and
// decodes them into a per-page register file: a 64-bit host address plus an
// ownership bit per huge page. Writes are staged and only land on a clean EOF
// beat, so discontinued or malformed TLPs never disturb the register file.
// Optional feature macro: HP_WRITE_PROTECT_EN (drops address writes to pages
// currently owned by hardware and pulses wr_violation).
module rx_huge_page_cfg_decoder #(
  parameter int NUM_PAGES = 2,
  parameter int BAR_NUM   = 2
) (
  input  logic                     trn_clk,
  input  logic                     reset,
  input  logic [63:0]              trn_rd,
  input  logic [7:0]               trn_rrem_n,
  input  logic                     trn_rsof_n,
  input  logic                     trn_reof_n,
  input  logic                     trn_rsrc_rdy_n,
  input  logic                     trn_rsrc_dsc_n,
  input  logic [6:0]               trn_rbar_hit_n,
  input  logic                     trn_rdst_rdy_n,
  output logic [64*NUM_PAGES-1:0]  huge_page_addr,
  output logic [NUM_PAGES-1:0]     huge_page_to_hw,
  input  logic [NUM_PAGES-1:0]     huge_page_to_host,
  output logic                     wr_violation
);

  localparam int PG_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam logic [6:0] FMT_MWR32 = 7'b10_00000;
  localparam logic [6:0] FMT_MWR64 = 7'b11_00000;

  typedef enum logic [1:0] {S_IDLE, S_HDR2, S_DATA, S_DRAIN} state_t;

  // Payload DWs arrive big-endian on the wire; registers hold them byte-reversed.
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  logic beat, sof, eof, dsc;
  assign beat = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof  = ~trn_rsof_n;
  assign eof  = ~trn_reof_n;
  assign dsc  = ~trn_rsrc_dsc_n;

  // First header beat qualification
  logic [6:0] hdr_fmt;
  logic [9:0] hdr_len;
  logic       hdr_ok;
  assign hdr_fmt = trn_rd[62:56];
  assign hdr_len = trn_rd[41:32];
  assign hdr_ok  = ((hdr_fmt == FMT_MWR32) || (hdr_fmt == FMT_MWR64)) &&
                   !trn_rbar_hit_n[BAR_NUM] &&
                   ((hdr_len == 10'd1) || (hdr_len == 10'd2));

  // Staging registers
  state_t      state_q;
  logic        is64_q;
  logic        len2_q;
  logic [31:0] addr_q;
  logic [31:0] dw0_q;

  // TLP tracking FSM; staging captures the address and first DW along the way
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      is64_q  <= 1'b0;
      len2_q  <= 1'b0;
      addr_q  <= 32'd0;
      dw0_q   <= 32'd0;
    end else if (beat) begin
      case (state_q)
        S_IDLE: begin
          if (sof) begin
            if (dsc) begin
              state_q <= S_IDLE;
            end else if (hdr_ok) begin
              is64_q  <= hdr_fmt[5];
              len2_q  <= (hdr_len == 10'd2);
              // A one-beat TLP cannot carry a full header; drop it.
              state_q <= eof ? S_IDLE : S_HDR2;
            end else begin
              state_q <= eof ? S_IDLE : S_DRAIN;
            end
          end
        end
        S_HDR2: begin
          if (dsc) begin
            state_q <= S_IDLE;
          end else if (!is64_q && !len2_q) begin
            // MWr32 len1 completes here; any further beat is a malformed tail.
            state_q <= eof ? S_IDLE : S_DRAIN;
          end else begin
            addr_q  <= is64_q ? trn_rd[31:0] : trn_rd[63:32];
            dw0_q   <= trn_rd[31:0];
            state_q <= eof ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          state_q <= (dsc || eof) ? S_IDLE : S_DRAIN;
        end
        S_DRAIN: begin
          if (dsc || eof) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Commit decode: the final beat may itself carry the address and/or payload
  logic        commit_go;
  logic [31:0] c_addr;
  logic [31:0] c_dw0;
  logic [31:0] c_dw1;

  // Assemble the write from staging plus the current EOF beat
  always_comb begin
    commit_go = 1'b0;
    c_addr    = addr_q;
    c_dw0     = dw0_q;
    c_dw1     = 32'd0;
    if (beat && eof && !dsc) begin
      case (state_q)
        S_HDR2: begin
          if (!is64_q && !len2_q) begin
            commit_go = 1'b1;
            c_addr    = trn_rd[63:32];
            c_dw0     = trn_rd[31:0];
          end
        end
        S_DATA: begin
          commit_go = 1'b1;
          if (is64_q) begin
            c_dw0 = trn_rd[63:32];
            c_dw1 = trn_rd[31:0];
          end else begin
            c_dw1 = trn_rd[63:32];
          end
        end
        default: ;
      endcase
    end
  end

  logic [PG_W-1:0] c_page;
  logic            c_page_ok;
  logic [1:0]      c_reg0;
  logic [1:0]      c_reg1;
  logic            dw0_v;
  logic            dw1_v;

  assign c_page = c_addr[4 +: PG_W];
  // Power-of-two page count: every index is valid unless a single page uses a 1-bit index.
  assign c_page_ok = (NUM_PAGES == (1 << PG_W)) || (c_page == '0);
  assign c_reg0 = c_addr[3:2];
  assign c_reg1 = c_reg0 + 2'd1;
  assign dw0_v  = commit_go && c_page_ok;
  // Second DW goes to the next register; no wrap past the reserved slot.
  assign dw1_v  = dw0_v && len2_q && (c_reg0 != 2'd3);

  logic [NUM_PAGES-1:0] viol_pg;

  for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        hw_q, hw_d;
    logic        sel, prot, lo_we, hi_we0, hi_we1, db_set;

    assign sel = (c_page == PG_W'(gi));
`ifdef HP_WRITE_PROTECT_EN
    assign prot = hw_q;
`else
    assign prot = 1'b0;
`endif
    assign lo_we  = dw0_v && sel && (c_reg0 == 2'd0) && !prot;
    assign hi_we0 = dw0_v && sel && (c_reg0 == 2'd1) && !prot;
    assign hi_we1 = dw1_v && sel && (c_reg1 == 2'd1) && !prot;
    assign db_set = sel && ((dw0_v && (c_reg0 == 2'd2)) || (dw1_v && (c_reg1 == 2'd2)));
    assign viol_pg[gi] = prot && sel &&
                         ((dw0_v && (c_reg0 < 2'd2)) || (dw1_v && (c_reg1 < 2'd2)));

    // Next-state for this page; a doorbell beats a same-cycle return
    always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      hw_d = hw_q;
      if (lo_we) lo_d = bswap(c_dw0);
      if (hi_we0) hi_d = bswap(c_dw0);
      else if (hi_we1) hi_d = bswap(c_dw1);
      if (db_set) hw_d = 1'b1;
      else if (huge_page_to_host[gi]) hw_d = 1'b0;
    end

    // Page register file state
    always_ff @(posedge trn_clk or posedge reset) begin
      if (reset) begin
        lo_q <= 32'd0;
        hi_q <= 32'd0;
        hw_q <= 1'b0;
      end else begin
        lo_q <= lo_d;
        hi_q <= hi_d;
        hw_q <= hw_d;
      end
    end

    assign huge_page_addr[64*gi +: 64] = {hi_q, lo_q};
    assign huge_page_to_hw[gi]         = hw_q;
  end

`ifdef HP_WRITE_PROTECT_EN
  logic wr_violation_q, wr_violation_d;
  assign wr_violation_d = |viol_pg;

  // One-cycle pulse when any DW of a commit was dropped
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) wr_violation_q <= 1'b0;
    else       wr_violation_q <= wr_violation_d;
  end
  assign wr_violation = wr_violation_q;
`else
  logic unused_viol;
  assign unused_viol  = |viol_pg;
  assign wr_violation = 1'b0;
`endif

  // Inputs and address bits that carry no meaning for this decoder
  logic unused_ok;
  assign unused_ok = ^{trn_rd, trn_rrem_n, trn_rbar_hit_n, c_addr};

endmodule

// File: tb/tb_rx_huge_page_cfg_decoder.sv
// tb_rx_huge_page_cfg_decoder
// Drives whole TLPs beat by beat, keeps a transaction-level model of the page
// register file, and compares every DUT output against it on each falling edge.
`timescale 1ns/1ps
module tb_rx_huge_page_cfg_decoder;

  localparam int NUM_PAGES = 2;
  localparam int BAR_NUM   = 2;
  localparam int PG_W      = 1;
  localparam logic [6:0] MWR32 = 7'b10_00000;
  localparam logic [6:0] MWR64 = 7'b11_00000;
  localparam logic [6:0] MRD64 = 7'b01_00000;
  localparam logic [6:0] MRD32 = 7'b00_00000;
`ifdef HP_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic [63:0]             trn_rd = '0;
  logic [7:0]              trn_rrem_n = '0;
  logic                    trn_rsof_n = 1'b1;
  logic                    trn_reof_n = 1'b1;
  logic                    trn_rsrc_rdy_n = 1'b1;
  logic                    trn_rsrc_dsc_n = 1'b1;
  logic [6:0]              trn_rbar_hit_n = 7'h7F;
  logic                    trn_rdst_rdy_n = 1'b0;
  logic [64*NUM_PAGES-1:0] huge_page_addr;
  logic [NUM_PAGES-1:0]    huge_page_to_hw;
  logic [NUM_PAGES-1:0]    host_drv = '0;
  logic                    wr_violation;

  always #5 clk = ~clk;

  rx_huge_page_cfg_decoder #(.NUM_PAGES(NUM_PAGES), .BAR_NUM(BAR_NUM)) dut (
    .trn_clk(clk), .reset(reset), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rbar_hit_n(trn_rbar_hit_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .huge_page_addr(huge_page_addr),
    .huge_page_to_hw(huge_page_to_hw), .huge_page_to_host(host_drv),
    .wr_violation(wr_violation)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rand_host = 1'b0;
  logic [NUM_PAGES-1:0] eof_host = '0;

  // Model state: what the outputs must show after each edge
  logic [63:0]          m_addr [NUM_PAGES];
  logic [NUM_PAGES-1:0] m_hw = '0;
  logic                 m_viol = 1'b0;

  // Pending commit description for the EOF beat
  logic [31:0] cm_addr, cm_d0, cm_d1;
  int          cm_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NUM_PAGES; p++)
        check($sformatf("addr_pg%0d", p), huge_page_addr[64*p +: 64], m_addr[p]);
      check("to_hw", 64'(huge_page_to_hw), 64'(m_hw));
      check("wr_violation", 64'(wr_violation), 64'(m_viol));
    end
  end

  task automatic model_dw(input int pg, input int r, input logic [31:0] d,
                          inout logic [NUM_PAGES-1:0] db, inout bit v);
    logic [31:0] sw;
    sw = {d[7:0], d[15:8], d[23:16], d[31:24]};
    if (r == 0) begin
      if (PROT && m_hw[pg]) v = 1'b1; else m_addr[pg][31:0] = sw;
    end else if (r == 1) begin
      if (PROT && m_hw[pg]) v = 1'b1; else m_addr[pg][63:32] = sw;
    end else if (r == 2) begin
      db[pg] = 1'b1;
    end
  endtask

  // One clock: current inputs are consumed at the edge, then the model advances
  task automatic tick(input bit commit);
    logic [NUM_PAGES-1:0] db;
    bit v;
    int pg, r;
    if (rand_host) host_drv = ($urandom_range(0, 5) == 0) ? NUM_PAGES'($urandom) : '0;
    @(posedge clk);
    db = '0;
    v  = 1'b0;
    if (commit) begin
      pg = int'((cm_addr >> 4) & ((32'd1 << PG_W) - 32'd1));
      if (pg < NUM_PAGES) begin
        r = int'(cm_addr[3:2]);
        model_dw(pg, r, cm_d0, db, v);
        if (cm_len == 2 && r < 3) model_dw(pg, r + 1, cm_d1, db, v);
      end
    end
    m_hw   = (m_hw & ~host_drv) | db;
    m_viol = v;
    #1;
    host_drv = '0;
  endtask

  task automatic idle(input int n);
    trn_rsrc_rdy_n = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    trn_rsof_n = 1'b1;
    trn_reof_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    for (int k = 0; k < n; k++) tick(1'b0);
  endtask

  task automatic pulse_host(input logic [NUM_PAGES-1:0] mask);
    idle(0);
    host_drv = mask;
    tick(1'b0);
  endtask

  task automatic send_tlp(input logic [6:0] fmt, input int len, input logic [31:0] addr,
                          input logic [31:0] d0, input logic [31:0] d1, input bit bar_ok,
                          input int dsc_at, input int nb_delta, input int stall_at,
                          input int stall_len, input bit stall_src);
    logic [63:0] beats [4];
    int nat, nb;
    bit acc, dsc_hit, commit;
    beats[0] = {1'b0, fmt, 14'd0, 10'(len), 32'($urandom)};
    beats[3] = {32'($urandom), 32'($urandom)};
    if (fmt == MWR32) begin
      beats[1] = {addr, d0};
      beats[2] = {d1, 32'($urandom)};
      nat = (len == 1) ? 2 : 3;
    end else if (fmt == MWR64) begin
      beats[1] = {32'($urandom), addr};
      beats[2] = {d0, d1};
      nat = 3;
    end else begin
      beats[1] = {addr, 32'($urandom)};
      beats[2] = {32'($urandom), 32'($urandom)};
      nat = 2;
    end
    nb = nat + nb_delta;
    if (nb < 1) nb = 1;
    if (nb > 4) nb = 4;
    acc     = (fmt == MWR32 || fmt == MWR64) && bar_ok && (len == 1 || len == 2);
    dsc_hit = (dsc_at >= 0) && (dsc_at < nb);
    commit  = acc && !dsc_hit && (nb == nat);
    cm_addr = addr;
    cm_d0   = d0;
    cm_d1   = d1;
    cm_len  = len;
    trn_rbar_hit_n = bar_ok ? 7'h7B : 7'h7E;
    for (int i = 0; i < nb; i++) begin
      trn_rd         = beats[i];
      trn_rsof_n     = (i != 0);
      trn_reof_n     = (i != nb - 1);
      trn_rsrc_dsc_n = (i != dsc_at);
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          trn_rsrc_rdy_n = stall_src;
          trn_rdst_rdy_n = !stall_src;
          tick(1'b0);
        end
      end
      trn_rsrc_rdy_n = 1'b0;
      trn_rdst_rdy_n = 1'b0;
      if (i == nb - 1 && eof_host != '0) host_drv = eof_host;
      tick(commit && (i == nb - 1));
    end
    eof_host = '0;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    $display("TLP fmt=%b len=%0d addr=%h d0=%h d1=%h bar_ok=%0d beats=%0d commit=%0d",
             fmt, len, addr, d0, d1, bar_ok, nb, commit);
  endtask

  initial begin
    for (int p = 0; p < NUM_PAGES; p++) m_addr[p] = '0;
    #2 reset = 1'b1;
    #1;
    chk_en = 1'b1;
    check("reset_addr", huge_page_addr[63:0], 64'h0);
    check("reset_addr_pg1", huge_page_addr[127:64], 64'h0);
    check("reset_to_hw", 64'(huge_page_to_hw), 64'h0);
    check("reset_viol", 64'(wr_violation), 64'h0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Register writes with byte-swapped payload
    send_tlp(MWR32, 1, 32'h0000_0000, 32'h7856_3412, 32'h0, 1, -1, 0, -1, 0, 0);
    send_tlp(MWR32, 1, 32'h0000_0004, 32'h0100_0000, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t1_page0", huge_page_addr[63:0], 64'h0000_0001_1234_5678);
    idle(1);
    send_tlp(MWR64, 2, 32'h0000_0010, 32'h0010_0000, 32'h0200_0000, 1, -1, 0, -1, 0, 0);
    check("t2_page1", huge_page_addr[127:64], 64'h0000_0002_0000_1000);
    check("t2_page0", huge_page_addr[63:0], 64'h0000_0001_1234_5678);
    idle(1);

    // Doorbell and return
    send_tlp(MWR32, 1, 32'h0000_0018, 32'hCAFE_F00D, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t3_doorbell", 64'(huge_page_to_hw), 64'h2);
    pulse_host(2'b10);
    check("t3_return", 64'(huge_page_to_hw), 64'h0);
    eof_host = 2'b10;
    send_tlp(MWR32, 1, 32'h0000_0018, 32'h0000_0000, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t3_set_wins", 64'(huge_page_to_hw), 64'h2);

    // Discontinued write, then a back-to-back good one
    send_tlp(MWR32, 1, 32'h0000_0000, 32'hAABB_CCDD, 32'h0, 1, 1, 0, -1, 0, 0);
    check("t4_dsc_nochange", huge_page_addr[63:0], 64'h0000_0001_1234_5678);
    send_tlp(MWR32, 1, 32'h0000_0000, 32'h4433_2211, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t4_b2b", huge_page_addr[63:0], 64'h0000_0001_1122_3344);

    // Rejected TLPs, then a stalled len2 write (ADDR_HI + DOORBELL of page 0)
    send_tlp(MRD64, 1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1, -1, 0, -1, 0, 0);
    send_tlp(MWR32, 1, 32'h0000_0000, 32'h2222_2222, 32'h0, 0, -1, 0, -1, 0, 0);
    send_tlp(MWR32, 3, 32'h0000_0000, 32'h3333_3333, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t5_rejects", huge_page_addr[63:0], 64'h0000_0001_1122_3344);
    send_tlp(MWR32, 2, 32'h0000_0004, 32'h0500_0000, 32'h1, 1, -1, 0, 1, 5, 0);
    check("t5_stall", huge_page_addr[63:0], 64'h0000_0005_1122_3344);
    check("t5_stall_hw", 64'(huge_page_to_hw), 64'h3);

    // Address write to an owned page
    send_tlp(MWR32, 1, 32'h0000_0000, 32'hEFBE_ADDE, 32'h0, 1, -1, 0, -1, 0, 0);
    check("t6_owned_write", huge_page_addr[63:0],
          PROT ? 64'h0000_0005_1122_3344 : 64'h0000_0005_DEAD_BEEF);
    check("t6_viol", 64'(wr_violation), 64'(PROT));
    idle(1);
    check("t6_viol_end", 64'(wr_violation), 64'h0);
    send_tlp(MWR32, 2, 32'h0000_0004, 32'h0900_0000, 32'h0, 1, -1, 0, -1, 0, 0);
    pulse_host(2'b11);
    idle(2);

    // Randomized traffic
    rand_host = 1'b1;
    for (int t = 0; t < 300; t++) begin
      logic [6:0] fmt;
      int sel, len, dsc_at, nbd, stall_at;
      logic [31:0] addr;
      sel = $urandom_range(0, 9);
      fmt = (sel == 0) ? MRD64 : (sel == 1) ? MRD32 : (sel < 6) ? MWR32 : MWR64;
      sel = $urandom_range(0, 9);
      len = (sel == 0) ? 0 : (sel == 1) ? 3 : (sel < 6) ? 1 : 2;
      addr = {32'($urandom) & 32'hFFFF_FFC0} | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      dsc_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      sel = $urandom_range(0, 9);
      nbd = (sel == 0) ? -1 : (sel == 1) ? 1 : 0;
      stall_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      send_tlp(fmt, len, addr, $urandom, $urandom, $urandom_range(0, 7) != 0,
               dsc_at, nbd, stall_at, $urandom_range(1, 5), 1'($urandom));
      idle($urandom_range(0, 2));
    end
    rand_host = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
